// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one uart_tx between NUM_REQ byte producers. Each producer
//            owns a one-byte holding register; a round-robin scheduler issues
//            held bytes one at a time and waits for each transmission to end.
// Options  : UART_ARB_PACKET_LOCK_EN - keep the grant on one requester until
//            it issues a byte flagged as end-of-packet.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GW      = $clog2(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_write_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_busy_o,
  output logic [NUM_REQ-1:0]   overrun_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 tx_write_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_busy_i
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    SETTLE    = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] overrun;
  logic [NUM_REQ-1:0] grant;
  logic [7:0]         hold_data [NUM_REQ];
  logic [7:0]         tx_data;
  logic [GW-1:0]      last;
  logic [GW-1:0]      winner;
  logic [GW-1:0]      pick;
  logic               found;
  logic               do_load;
  logic               do_issue;
  logic               do_done;
  logic [GW:0]        rr_sum;
  logic [GW-1:0]      rr_idx;

`ifdef UART_ARB_PACKET_LOCK_EN
  logic [NUM_REQ-1:0] hold_last;
  logic               lock;
`else
  // End-of-packet flags have no meaning without packet locking.
  logic               unused_last;
  assign unused_last = ^req_last_i;
`endif

  assign req_busy_o = pending;
  assign overrun_o  = overrun;
  assign grant_o    = grant;
  assign tx_data_o  = tx_data;
  assign tx_write_o = (state == ISSUE);

  // Holding registers: accept into an empty slot, flag overrun on a full one,
  // release the slot when its byte is issued.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pending <= '0;
      overrun <= '0;
      for (int k = 0; k < NUM_REQ; k++) hold_data[k] <= 8'h00;
`ifdef UART_ARB_PACKET_LOCK_EN
      hold_last <= '0;
`endif
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_write_i[k]) begin
          if (pending[k]) begin
            overrun[k] <= 1'b1;
          end else begin
            hold_data[k] <= req_data_i[8*k +: 8];
            pending[k]   <= 1'b1;
`ifdef UART_ARB_PACKET_LOCK_EN
            hold_last[k] <= req_last_i[k];
`endif
          end
        end
        // An issued slot is always full, so this never races an accept.
        if (do_issue && (winner == GW'(k))) pending[k] <= 1'b0;
      end
    end
  end

  // Round-robin search starting one past the last issued requester.
  always_comb begin
    found  = 1'b0;
    pick   = last;
    rr_sum = '0;
    rr_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_sum = {1'b0, last} + (GW+1)'(i);
      if (rr_sum >= (GW+1)'(NUM_REQ)) rr_sum = rr_sum - (GW+1)'(NUM_REQ);
      rr_idx = rr_sum[GW-1:0];
      if (!found && pending[rr_idx]) begin
        found = 1'b1;
        pick  = rr_idx;
      end
    end
`ifdef UART_ARB_PACKET_LOCK_EN
    // While a packet is open only its owner may be issued.
    if (lock) begin
      found = pending[last];
      pick  = last;
    end
`endif
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_issue   = 1'b0;
    do_done    = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy_i && found) begin
          do_load    = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        do_issue   = 1'b1;
        state_next = SETTLE;
      end
      // uart_tx busy may still be low here, so it is not looked at.
      SETTLE: state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx_busy_i) begin
          do_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Transmit byte, grant and rotation pointer.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tx_data <= 8'h00;
      grant   <= '0;
      winner  <= '0;
      last    <= GW'(NUM_REQ - 1);
`ifdef UART_ARB_PACKET_LOCK_EN
      lock    <= 1'b0;
`endif
    end else begin
      if (do_load) begin
        tx_data <= hold_data[pick];
        grant   <= NUM_REQ'(1) << pick;
        winner  <= pick;
      end
      if (do_issue) begin
        last <= winner;
`ifdef UART_ARB_PACKET_LOCK_EN
        lock <= !hold_last[winner];
`endif
      end
      if (do_done) grant <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter with a behavioural
//            uart_tx busy model and an in-order issue scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int BUSY_CYC = 3;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_write_i = '0;
  logic [8*N-1:0] req_data_i = '0;
  logic [N-1:0]   req_last_i = '0;
  logic [N-1:0]   req_busy_o;
  logic [N-1:0]   overrun_o;
  logic [N-1:0]   grant_o;
  logic           tx_write_o;
  logic [7:0]     tx_data_o;
  logic           tx_busy_i;

  int          total = 0;
  int          bad = 0;
  int          busy_cnt = 0;
  logic [10:0] sb [$];
  logic [10:0] exp_e;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_write_i (req_write_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_busy_o  (req_busy_o),
    .overrun_o   (overrun_o),
    .grant_o     (grant_o),
    .tx_write_o  (tx_write_o),
    .tx_data_o   (tx_data_o),
    .tx_busy_i   (tx_busy_i)
  );

  always #5 clock = ~clock;

  // uart_tx model: busy rises the cycle after write and lasts BUSY_CYC cycles.
  assign tx_busy_i = (busy_cnt != 0);
  always @(posedge clock) begin
    if (tx_write_o)        busy_cnt <= BUSY_CYC;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Every issue pulse is compared against the oldest expected byte.
  always @(negedge clock) begin
    if (tx_write_o === 1'b1) begin
      check("busy_at_issue", 32'(tx_busy_i), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        exp_e = sb.pop_front();
        check("tx_data", 32'(tx_data_o), 32'(exp_e[7:0]));
        check("grant", 32'(grant_o), 32'(1) << exp_e[10:8]);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put_req(input int k, input logic [7:0] d, input logic l);
    req_write_i[k]         = 1'b1;
    req_data_i[8*k +: 8]   = d;
    req_last_i[k]          = l;
  endtask

  task automatic commit();
    tick();
    req_write_i = '0;
    req_last_i  = '0;
  endtask

  task automatic expect_byte(input int k, input logic [7:0] d);
    sb.push_back({3'(k), d});
  endtask

  task automatic wait_low(input int k);
    int n;
    n = 0;
    while (req_busy_o[k] !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check("wait_low_timeout", 32'(n >= 200), 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || tx_busy_i || grant_o != '0 || req_busy_o != '0) && n < 500) begin
      tick();
      n++;
    end
    tick();
    check("wait_idle_timeout", 32'(n >= 500), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    32'(req_busy_o), 32'd0);
    check({tag, "_overrun"}, 32'(overrun_o),  32'd0);
    check({tag, "_grant"},   32'(grant_o),    32'd0);
    check({tag, "_write"},   32'(tx_write_o), 32'd0);
    check({tag, "_data"},    32'(tx_data_o),  32'd0);
  endtask

  initial begin
    // Reset values
    reset_n = 1'b0;
    tick();
    tick();
    @(negedge clock);
    check_reset_outputs("rst");
    tick();
    reset_n = 1'b1;
    tick();

    // Single byte: write in t, busy t+1..t+2, issue at t+2, busy low t+3
    expect_byte(2, 8'h5A);
    put_req(2, 8'h5A, 1'b0);
    commit();
    @(negedge clock);
    check("single_busy_t1", 32'(req_busy_o), 32'b0100);
    check("single_nowrite_t1", 32'(tx_write_o), 32'd0);
    tick();
    @(negedge clock);
    check("single_busy_t2", 32'(req_busy_o[2]), 32'd1);
    check("single_write_t2", 32'(tx_write_o), 32'd1);
    check("single_data_t2", 32'(tx_data_o), 32'h5A);
    check("single_grant_t2", 32'(grant_o), 32'b0100);
    tick();
    @(negedge clock);
    check("single_busy_t3", 32'(req_busy_o[2]), 32'd0);
    check("single_hold_data", 32'(tx_data_o), 32'h5A);
    wait_idle();

    // Contention from reset: requester 0 has first priority
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < N; k++) begin
      expect_byte(k, 8'h10 + 8'(k));
      put_req(k, 8'h10 + 8'(k), 1'b0);
    end
    commit();
    wait_idle();

    // Fairness: 0 and 3 keep rewriting as soon as their slot empties
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    expect_byte(0, 8'hA0);
    expect_byte(3, 8'h33);
    put_req(0, 8'hA0, 1'b0);
    put_req(3, 8'h33, 1'b0);
    commit();
    for (int r = 0; r < 3; r++) begin
      wait_low(0);
      expect_byte(0, 8'hA1 + 8'(r));
      put_req(0, 8'hA1 + 8'(r), 1'b0);
      commit();
      wait_low(3);
      expect_byte(3, 8'h34 + 8'(r));
      put_req(3, 8'h34 + 8'(r), 1'b0);
      commit();
    end
    wait_idle();

    // Overrun: second write while busy is dropped and flagged
    expect_byte(1, 8'hAA);
    put_req(1, 8'hAA, 1'b0);
    commit();
    put_req(1, 8'hBB, 1'b0);
    commit();
    @(negedge clock);
    check("overrun_set", 32'(overrun_o), 32'b0010);
    wait_idle();
    check("overrun_sticky", 32'(overrun_o), 32'b0010);

    // Reset while waiting on the transmitter with 0 and 2 pending
    expect_byte(1, 8'h77);
    put_req(1, 8'h77, 1'b0);
    commit();
    put_req(0, 8'hC0, 1'b0);
    put_req(2, 8'hC2, 1'b0);
    commit();
    tick();
    tick();
    @(negedge clock);
    check("midrst_pending", 32'(req_busy_o), 32'b0101);
    check("midrst_grant", 32'(grant_o), 32'b0010);
    reset_n = 1'b0;
    tick();
    @(negedge clock);
    check_reset_outputs("midrst");
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    check("midrst_quiet", 32'({req_busy_o, grant_o}), 32'd0);
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);

    // Packet stimulus: 0 sends three bytes (last on third), 1 joins after first
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
`ifdef UART_ARB_PACKET_LOCK_EN
    expect_byte(0, 8'hC1);
    expect_byte(0, 8'hC2);
    expect_byte(0, 8'hC3);
    expect_byte(1, 8'hD1);
`else
    expect_byte(0, 8'hC1);
    expect_byte(1, 8'hD1);
    expect_byte(0, 8'hC2);
    expect_byte(0, 8'hC3);
`endif
    put_req(0, 8'hC1, 1'b0);
    commit();
    wait_low(0);
    put_req(1, 8'hD1, 1'b0);
    put_req(0, 8'hC2, 1'b0);
    commit();
    wait_low(0);
    put_req(0, 8'hC3, 1'b1);
    commit();
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
